// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the MEM stage of an RV32IM core.
//   It answers loads and stores after LATENCY wait cycles. Byte, half and
//   word lanes are selected from funct3/addr, and loads are sign- or
//   zero-extended. The combinational busy output stalls the pipeline until
//   the access reaches DONE.
//
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses are flagged. They perform no
//                 write, and a load returns 0.
//     undefined : low address bits are forced aligned, and misaligned = 0.
//
// Parameters
//   DEPTH_WORDS : storage size in 32-bit words (power of two)
//   LATENCY     : WAIT cycles per access (0..15)
// Ports
//   clk        in   clock, rising edge
//   reset      in   async active-low reset
//   mem_read   in   load request
//   mem_write  in   store request (wins over mem_read)
//   addr       in   byte address
//   funct3     in   access size / extension
//   write_data in   store data, right-aligned
//   read_data  out  registered load result, updated on entry to DONE
//   busy       out  combinational stall request
//   misaligned out  registered, valid in DONE
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        misaligned
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic       LAT_ZERO = (LATENCY == 0);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          req, commit;
  logic [AW-1:0] widx;

  // Contents survive reset and start at zero.
  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  assign req  = mem_read | mem_write;
  assign widx = addr[AW+1:2];

  // Upper address bits wrap away by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign busy = reset & (((state == S_IDLE) & req) | (state == S_WAIT));

  // Commit fires on the edge that enters DONE. Gating it with reset keeps a
  // store from landing while reset is held.
  assign commit = reset & (((state == S_IDLE) & req & LAT_ZERO) |
                           ((state == S_WAIT) & (cnt == 4'd0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          if (LAT_ZERO) state <= S_DONE;
          else begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        S_WAIT: if (cnt == 4'd0) state <= S_DONE;
                else             cnt   <= cnt - 4'd1;
        // The request is still presented during DONE, so it is ignored here.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode. Encodings 011/110/111 fall through to word accesses.
  logic       is_byte, is_half, is_word, is_uns, mis;
  logic [1:0] a_lo;
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = ~is_byte & ~is_half;
  assign is_uns  = funct3[2];
  assign a_lo    = is_word ? 2'b00 : is_half ? {addr[1], 1'b0} : addr[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Store lane enables and data replicated across lanes.
  logic [3:0]  be;
  logic [31:0] wlanes;
  always_comb begin
    be     = 4'b1111;
    wlanes = write_data;
    if (is_byte) begin
      be     = 4'b0001 << a_lo;
      wlanes = {4{write_data[7:0]}};
    end else if (is_half) begin
      be     = a_lo[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{write_data[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (commit & mem_write & ~mis) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

  // Load lane extraction and extension.
  logic [31:0] word_rd, shifted, load_val;
  assign word_rd = mem[widx];
  assign shifted = word_rd >> {a_lo, 3'b000};
  always_comb begin
    load_val = word_rd;
    if (is_byte)
      load_val = is_uns ? {24'h0, shifted[7:0]}
                        : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_val = is_uns ? {16'h0, shifted[15:0]}
                        : {{16{shifted[15]}}, shifted[15:0]};
  end

  // misaligned is raised only for the DONE cycle. A store leaves read_data
  // untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data  <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= commit & mis;
      if (commit & ~mem_write)
        read_data <= mis ? 32'h0 : load_val;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_read0, mem_write0;
  logic [31:0] addr, write_data;
  logic [2:0]  funct3;
  logic [31:0] read_data, read_data0;
  logic        busy, busy0, misaligned, misaligned0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .funct3(funct3), .write_data(write_data),
    .read_data(read_data), .busy(busy), .misaligned(misaligned));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr), .funct3(funct3), .write_data(write_data),
    .read_data(read_data0), .busy(busy0), .misaligned(misaligned0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Count cycles with busy high, bounded. On return the bench sits in DONE.
  task automatic wait_done(input bit sel, output int nb);
    nb = 0;
    #1;
    while (((sel ? busy0 : busy) === 1'b1) && nb < 40) begin
      nb++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic access(input bit sel, input bit wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int nb);
    @(negedge clk);
    addr = a; funct3 = f3; write_data = wd;
    if (sel) begin mem_read0 = ~wr; mem_write0 = wr; end
    else     begin mem_read  = ~wr; mem_write  = wr; end
    wait_done(sel, nb);
    rd  = sel ? read_data0 : read_data;
    mis = sel ? misaligned0 : misaligned;
    @(negedge clk);
    mem_read = 0; mem_write = 0; mem_read0 = 0; mem_write0 = 0;
  endtask

  task automatic ld(input string tag, input bit sel, input logic [31:0] a,
                    input logic [2:0] f3, input logic [31:0] exp, input int exp_nb);
    logic [31:0] rd; logic mis; int nb;
    access(sel, 1'b0, a, f3, 32'h0, rd, mis, nb);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_busy"}, nb, exp_nb);
  endtask

  task automatic st(input string tag, input bit sel, input logic [31:0] a,
                    input logic [2:0] f3, input logic [31:0] wd, input int exp_nb);
    logic [31:0] rd; logic mis; int nb;
    access(sel, 1'b1, a, f3, wd, rd, mis, nb);
    chk({tag, "_busy"}, nb, exp_nb);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          nb;
    reset = 0; mem_read = 1; mem_write = 0; mem_read0 = 0; mem_write0 = 0;
    addr = 32'h10; funct3 = 3'b010; write_data = 0;

    // Held in reset with a request present.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_mis", misaligned, 0);
    @(negedge clk);
    reset = 1;
    wait_done(1'b0, nb);
    chk("rel_busy", nb, 3);
    chk("rel_rdata", read_data, 0);
    @(negedge clk);
    mem_read = 0;

    st("sw10", 0, 32'h10, 3'b010, 32'hDEADBEEF, 3);
    ld("lw10", 0, 32'h10, 3'b010, 32'hDEADBEEF, 3);
    ld("lb13", 0, 32'h13, 3'b000, 32'hFFFFFFDE, 3);
    ld("lbu13", 0, 32'h13, 3'b100, 32'h000000DE, 3);
    ld("lh12", 0, 32'h12, 3'b001, 32'hFFFFDEAD, 3);
    ld("lhu10", 0, 32'h10, 3'b101, 32'h0000BEEF, 3);

    // A store leaves read_data at the last load value.
    access(0, 1'b1, 32'h11, 3'b000, 32'h00000055, rd, mis, nb);
    chk("sb_rd_hold", rd, 32'h0000BEEF);
    ld("lw_sb", 0, 32'h10, 3'b010, 32'hDEAD55EF, 3);
    ld("lw_wrap", 0, 32'h1010, 3'b010, 32'hDEAD55EF, 3);
    st("sh12", 0, 32'h12, 3'b001, 32'h00001234, 3);
    ld("lw_sh", 0, 32'h10, 3'b010, 32'h123455EF, 3);

`ifdef DMEM_MISALIGN_TRAP_EN
    access(0, 1'b1, 32'h11, 3'b010, 32'hFFFFFFFF, rd, mis, nb);
    chk("sw_mis_flag", mis, 1);
    #1 chk("sw_mis_clear", misaligned, 0);
    access(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, mis, nb);
    chk("lw_after_mis", rd, 32'h123455EF);
    chk("lw_after_mis_flag", mis, 0);
    access(0, 1'b0, 32'h13, 3'b001, 32'h0, rd, mis, nb);
    chk("lh_mis_data", rd, 0);
    chk("lh_mis_flag", mis, 1);
`else
    access(0, 1'b0, 32'h13, 3'b001, 32'h0, rd, mis, nb);
    chk("lh13_align", rd, 32'h00001234);
    chk("lh13_nomis", mis, 0);
    ld("lw13_align", 0, 32'h13, 3'b010, 32'h123455EF, 3);
    st("sw33", 0, 32'h33, 3'b010, 32'hCAFEF00D, 3);
    ld("lw30", 0, 32'h30, 3'b010, 32'hCAFEF00D, 3);
`endif

    // Reset pulse during WAIT drops the store.
    @(negedge clk);
    addr = 32'h20; funct3 = 3'b010; write_data = 32'hAAAAAAAA; mem_write = 1;
    #1 chk("rp_busy_req", busy, 1);
    @(negedge clk);
    reset = 0;
    #1 chk("rp_busy_rst", busy, 0);
    mem_write = 0;
    @(negedge clk);
    reset = 1;
    #1 chk("rp_busy_idle", busy, 0);
    ld("rp_lw20", 0, 32'h20, 3'b010, 32'h0, 3);

    // LATENCY = 0 instance.
    st("l0_sw8", 1, 32'h8, 3'b010, 32'h11223344, 1);
    ld("l0_lw8", 1, 32'h8, 3'b010, 32'h11223344, 1);
    ld("l0_lb9", 1, 32'h9, 3'b000, 32'h00000033, 1);
    ld("l0_lhA", 1, 32'hA, 3'b001, 32'h00001122, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the RV32IM pipelined core. It sits at the MEM stage and answers the core's load/store requests. It applies RISC-V byte, half and word lane selection, with sign or zero extension on loads, from funct3. It also drives a combinational `busy` stall, so the pipeline holds EX/MEM and the earlier stages until the access completes.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; must be a power of two.
- `LATENCY`, 2: number of WAIT cycles per access, legal range 0..15.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `mem_read`  in  1  — load request.
- `mem_write`  in  1  — store request; has priority if both it and `mem_read` are high.
- `addr`  in  32  — byte address of the access.
- `funct3`  in  3  — access size and extension: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- `write_data`  in  32  — store data, right-aligned.
- `read_data`  out  32  — registered load result; stays constant outside DONE.
- `busy`  out  1  — stall request to the core; combinational.
- `misaligned`  out  1  — registered flag, valid in DONE.

## Operation
- `req = mem_read | mem_write`.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so accesses wrap modulo the storage size.
- FSM states are IDLE, WAIT and DONE.
  - IDLE → WAIT when `req` is high and `LATENCY > 0`; the down-counter loads `LATENCY-1`.
  - IDLE → DONE when `req` is high and `LATENCY = 0`.
  - WAIT: the counter decrements each cycle. WAIT → DONE when the counter is 0.
  - DONE → IDLE unconditionally. `req` is ignored in DONE, because the same request is still presented during that cycle.
- `busy = reset & ((IDLE & req) | WAIT)`. It is low in DONE, and the core advances on the edge that ends DONE.
- The core must hold `addr`, `funct3`, `write_data` and the request lines stable while `busy` is high. The responder samples them on the edge that enters DONE.
- Commit happens on the edge entering DONE.
  - Store: write the byte lanes selected by `funct3` and `addr[1:0]`. SB uses lane `addr[1:0]`, SH uses lanes `{addr[1],0}` and `{addr[1],1}`, SW uses all four lanes.
  - Load: `read_data` takes the selected lane(s). LB and LH sign-extend; LBU, LHU and LW zero-extend.
- `funct3` values 011, 110 and 111 are treated as word accesses.
- A store does not modify `read_data`.
- Reset values: `read_data` = 0, `misaligned` = 0, state = IDLE, counter = 0, `busy` = 0.
- Reset asserted mid-access returns the FSM to IDLE at once. A store that has not yet reached DONE is dropped.
- Storage contents are not affected by reset and are initialised to zero at time 0.

## Timing
- With `LATENCY = L`, a request occupies L+2 cycles: 1 IDLE cycle, L WAIT cycles and 1 DONE cycle. `busy` is high for the first L+1 of them.
- With L=2: request in cycle 0, WAIT in cycles 1–2, DONE in cycle 3 (`read_data` valid, `busy` = 0), IDLE in cycle 4.
- A new request can be accepted in the cycle immediately after DONE. Back-to-back requests therefore cost L+2 cycles each.
- A load in DONE returns data written by a store whose DONE was in any earlier cycle.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`.
- When defined:
  - An access is misaligned if it is LH, LHU or SH with `addr[0] = 1`, or LW or SW with `addr[1:0] ≠ 00`.
  - A misaligned access performs no write and loads 0 into `read_data`.
  - `misaligned` is 1 in DONE and 0 in every other cycle.
- When not defined:
  - The low address bits are forced aligned: `addr[0]` is ignored for half accesses and `addr[1:0]` is ignored for word accesses.
  - `misaligned` is tied to 0.
- FSM timing is identical in both builds.

## Test plan
- Reset, L=2: hold `reset` = 0 with `mem_read` = 1 → `busy` = 0, `read_data` = 0. Release reset → `busy` rises in the same cycle and `read_data` = 0 in DONE at cycle 3.
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `read_data` = 0xDEADBEEF in DONE, and `busy` is high for exactly 3 cycles per access.
- Load byte and half after that store:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x10 → 0x0000BEEF
- SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF. SH 0x1234 to 0x12, then LW 0x10 → 0x123455EF.
- With `DMEM_MISALIGN_TRAP_EN`: SW 0xFFFFFFFF to 0x11 → `misaligned` = 1 for one cycle, and a subsequent LW 0x10 is unchanged. LH 0x13 → `read_data` = 0 and `misaligned` = 1.
- Reset pulse during WAIT of SW 0xAAAAAAAA to 0x20 → FSM returns to IDLE and `busy` drops. A following LW 0x20 returns the prior value.
- Wrap: with `DEPTH_WORDS` = 1024, LW `4096+0x10` → 0xDEAD55EF.
- With L=0: each access takes 2 cycles and `busy` is high only in the IDLE cycle.
